elevator_request_scheduler: RTL and testbench

Request latch and LOOK-policy scheduler for the 4-floor car. It collects cab (`floor_btn`) and hall (`call_btn`) presses into a pending register and chooses the next target floor and travel direction. It hands the target to the car controller over a level-valid interface. When the car is idle for too long, it parks the car at a home floor. It sits between the button inputs and the car controller, and watches the car's `current_floor`, `open_door`, `busy` and `overload`.

---
 rtl/elevator_request_scheduler_if.sv | 25 ++
 rtl/elevator_request_scheduler.sv | 144 ++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_request_scheduler_if.sv
// Car-controller link: target floor/direction out, car position and status in.
// Latency: none, wires only.
// Backpressure: level-valid target; the car consumes target_floor while target_valid is high.
interface elevator_request_scheduler_if;
  logic [1:0] current_floor;
  logic       open_door;
  logic       busy;
  logic       overload;
  logic [1:0] target_floor;
  logic       target_valid;
  logic       dir_up;
  logic       dir_down;

  // Scheduler side: drives the target, watches the car.
  modport master (
    input  current_floor, open_door, busy, overload,
    output target_floor, target_valid, dir_up, dir_down
  );

  // Car controller side.
  modport slave (
    output current_floor, open_door, busy, overload,
    input  target_floor, target_valid, dir_up, dir_down
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// Latches cab/hall presses and picks the next target floor with a LOOK policy; parks at HOME_FLOOR when idle.
// Latency: press -> pending 1 cycle, press -> target 2 cycles; all outputs registered.
// Backpressure: overload freezes state, target and idle counter; pending keeps latching and clearing.
module elevator_request_scheduler #(
  parameter logic [1:0]  HOME_FLOOR   = 2'd0,
  parameter int unsigned IDLE_TIMEOUT = 50
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [3:0]                          floor_btn,
  input  logic [3:0]                          call_btn,
  output logic [3:0]                          pending,
  elevator_request_scheduler_if.master        car
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_HOME} state_t;

  localparam logic [7:0] TIMEOUT = 8'(IDLE_TIMEOUT);

  state_t     state, state_nxt;
  logic [1:0] tgt_q, tgt_nxt;
  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic       vld_q, up_q, dn_q;

  logic [3:0] clr;
  logic       up_found, dn_found;
  logic [1:0] up_f, dn_f;
  logic [1:0] up_dist, dn_dist;
  logic       idle_cond;

  // Door open at the current floor serves (and clears) that floor's request.
  always_comb begin
    clr = 4'b0000;
    if (car.open_door) clr = 4'b0001 << car.current_floor;
  end

  // Nearest pending floor at/above and at/below the car.
  always_comb begin
    up_found = 1'b0;
    up_f     = 2'd0;
    dn_found = 1'b0;
    dn_f     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i] && (2'(i) >= car.current_floor)) begin
        up_found = 1'b1;
        up_f     = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pending[i] && (2'(i) <= car.current_floor)) begin
        dn_found = 1'b1;
        dn_f     = 2'(i);
      end
    end
    up_dist = up_f - car.current_floor;
    dn_dist = car.current_floor - dn_f;
  end

  assign idle_cond = (state == S_IDLE) && (pending == 4'b0000) && !car.busy &&
                     (car.current_floor != HOME_FLOOR);

  // Next state, next target and idle counter; everything holds under overload.
  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt_q;
    idle_cnt_nxt = idle_cnt;
    if (!car.overload) begin
      idle_cnt_nxt = idle_cond ? idle_cnt + 8'd1 : 8'd0;
      unique case (state)
        S_IDLE: begin
          if (pending != 4'b0000) begin
            // Distance tie (and a request at the car's own floor) goes up.
            if (up_found && (!dn_found || (up_dist <= dn_dist))) begin
              state_nxt = S_UP;
              tgt_nxt   = up_f;
            end else begin
              state_nxt = S_DOWN;
              tgt_nxt   = dn_f;
            end
          end else if (idle_cond && (idle_cnt == TIMEOUT)) begin
            state_nxt = S_HOME;
            tgt_nxt   = HOME_FLOOR;
          end
        end
        S_UP: begin
          if (pending == 4'b0000) begin
            state_nxt = S_IDLE;
          end else if (up_found) begin
            tgt_nxt = up_f;
          end else begin
            state_nxt = S_DOWN;
            tgt_nxt   = dn_f;
          end
        end
        S_DOWN: begin
          if (pending == 4'b0000) begin
            state_nxt = S_IDLE;
          end else if (dn_found) begin
            tgt_nxt = dn_f;
          end else begin
            state_nxt = S_UP;
            tgt_nxt   = up_f;
          end
        end
        S_HOME: begin
          // A new request aborts parking; dispatch happens from IDLE.
          if (pending != 4'b0000) begin
            state_nxt = S_IDLE;
          end else if ((car.current_floor == HOME_FLOOR) && !car.busy) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, pending latch and registered output flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 4'b0000;
      state    <= S_IDLE;
      tgt_q    <= 2'd0;
      idle_cnt <= 8'd0;
      vld_q    <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      pending  <= (pending | floor_btn | call_btn) & ~clr;
      state    <= state_nxt;
      tgt_q    <= tgt_nxt;
      idle_cnt <= idle_cnt_nxt;
      vld_q    <= (state_nxt != S_IDLE);
      up_q     <= (state_nxt == S_UP);
      dn_q     <= (state_nxt == S_DOWN);
    end
  end

  assign car.target_floor = tgt_q;
  assign car.target_valid = vld_q;
  assign car.dir_up       = up_q;
  assign car.dir_down     = dn_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Self-checking bench for elevator_request_scheduler: directed table, corner sequences, random vs model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: overload exercised in directed and random phases.
module tb_elevator_request_scheduler;
  localparam int         T    = 8;
  localparam logic [1:0] HOME = 2'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] floor_btn;
  logic [3:0] call_btn;
  logic [3:0] pending;

  elevator_request_scheduler_if car_if();

  elevator_request_scheduler #(.HOME_FLOOR(HOME), .IDLE_TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .floor_btn (floor_btn),
    .call_btn  (call_btn),
    .pending   (pending),
    .car       (car_if.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_HOME = 3;
  int         m_state = M_IDLE;
  logic [3:0] m_pend  = 4'b0;
  logic [1:0] m_tgt   = 2'd0;
  int         m_run   = 0;

  task automatic model_step(input logic rst, input logic [3:0] fb, input logic [3:0] cb,
                            input logic [1:0] cf, input logic od, input logic busy, input logic ovl);
    int c, ns, nt, best, bestd, d;
    int above[$];
    int below[$];
    logic [3:0] clr_mask;
    bit idle_ok;
    if (rst) begin
      m_pend = 4'b0; m_state = M_IDLE; m_tgt = 2'd0; m_run = 0;
      return;
    end
    c  = int'(cf);
    ns = m_state;
    nt = int'(m_tgt);
    clr_mask = od ? 4'(1 << c) : 4'b0;
    for (int f = 0; f < 4; f++) begin
      if (m_pend[f] && f >= c) above.push_back(f);
      if (m_pend[f] && f <= c) below.push_back(f);
    end
    idle_ok = (m_state == M_IDLE) && (m_pend == 0) && !busy && (c != int'(HOME));
    if (!ovl) begin
      case (m_state)
        M_IDLE: begin
          if (m_pend != 0) begin
            best = -1; bestd = 99;
            for (int f = 0; f < 4; f++) begin
              if (m_pend[f]) begin
                d = (f > c) ? f - c : c - f;
                if (d < bestd || (d == bestd && f > c)) begin
                  best = f; bestd = d;
                end
              end
            end
            ns = (best >= c) ? M_UP : M_DOWN;
            nt = best;
          end else if (idle_ok && m_run >= T) begin
            ns = M_HOME;
            nt = int'(HOME);
          end
        end
        M_UP: begin
          if (m_pend == 0) ns = M_IDLE;
          else if (above.size() > 0) nt = above[0];
          else begin ns = M_DOWN; nt = below[$]; end
        end
        M_DOWN: begin
          if (m_pend == 0) ns = M_IDLE;
          else if (below.size() > 0) nt = below[$];
          else begin ns = M_UP; nt = above[0]; end
        end
        default: begin
          if (m_pend != 0) ns = M_IDLE;
          else if (c == int'(HOME) && !busy) ns = M_IDLE;
        end
      endcase
      m_run = idle_ok ? m_run + 1 : 0;
    end
    m_pend  = (m_pend | fb | cb) & ~clr_mask;
    m_state = ns;
    m_tgt   = 2'(nt);
  endtask

  function automatic logic [8:0] model_obs();
    return {m_pend, m_tgt, m_state != M_IDLE, m_state == M_UP, m_state == M_DOWN};
  endfunction

  // ---------------- drive / check helpers ----------------
  task automatic step(input logic rst, input logic [3:0] fb, input logic [3:0] cb,
                      input logic [1:0] cf, input logic od, input logic busy, input logic ovl);
    reset                = rst;
    floor_btn            = fb;
    call_btn             = cb;
    car_if.current_floor = cf;
    car_if.open_door     = od;
    car_if.busy          = busy;
    car_if.overload      = ovl;
    model_step(rst, fb, cb, cf, od, busy, ovl);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {pending, car_if.target_floor, car_if.target_valid, car_if.dir_up, car_if.dir_down};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got pend=%b tgt=%0d vld=%b up=%b dn=%b, want pend=%b tgt=%0d vld=%b up=%b dn=%b",
               name, got[8:5], got[4:3], got[2], got[1], got[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] fb, cb;
    logic [1:0] cf;
    logic       od, busy, ovl;
    logic [3:0] e_pend;
    logic [1:0] e_tgt;
    logic       e_vld, e_up, e_dn;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [1:0] cf;
    logic [3:0] fb, cb;
    logic       od, busy, ovl, rst;
    int         j;

    //           rst fb       cb       cf od bsy ovl  pend     tgt vld up dn
    // dispatch
    tbl.push_back('{1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b1000, 3, 1, 1, 0});
    // LOOK order from floor 1 with 1001, then press 0100
    tbl.push_back('{0, 4'b0001, 4'b0000, 1, 0, 1, 0, 4'b1001, 3, 1, 1, 0});
    tbl.push_back('{0, 4'b0100, 4'b0000, 1, 0, 1, 0, 4'b1101, 3, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 1, 0, 4'b1101, 2, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 2, 1, 1, 0, 4'b1001, 2, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 2, 0, 1, 0, 4'b1001, 3, 1, 1, 0});
    // clear priority at floor 3: door open and hall press at 3 together
    tbl.push_back('{0, 4'b0000, 4'b1000, 3, 1, 1, 0, 4'b0001, 3, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 3, 0, 1, 0, 4'b0001, 0, 1, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 3, 0, 1, 0, 4'b0001, 0, 1, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 1, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
    // tie-break at floor 1 with 0101
    tbl.push_back('{0, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0101, 0, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0101, 2, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 2, 1, 1, 0, 4'b0001, 2, 1, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 2, 0, 1, 0, 4'b0001, 0, 1, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 1, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
    // reset mid-travel; presses during reset discarded
    tbl.push_back('{0, 4'b0000, 4'b0100, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0100, 2, 1, 1, 0});
    tbl.push_back('{1, 4'b1111, 4'b1111, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].fb, tbl[i].cb, tbl[i].cf, tbl[i].od, tbl[i].busy, tbl[i].ovl);
      check($sformatf("tbl%0d", i),
            {tbl[i].e_pend, tbl[i].e_tgt, tbl[i].e_vld, tbl[i].e_up, tbl[i].e_dn});
    end

    // Parking: idle at floor 2, HOME on the 9th cycle, then abort by a hall call.
    step(1, 4'b0, 4'b0, 2, 0, 0, 0);
    for (int k = 1; k <= T; k++) begin
      step(0, 4'b0, 4'b0, 2, 0, 0, 0);
      check($sformatf("park_wait%0d", k), {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    step(0, 4'b0, 4'b0, 2, 0, 0, 0);
    check("park_home", {4'b0000, HOME, 1'b1, 1'b0, 1'b0});
    step(0, 4'b0, 4'b1000, 2, 0, 1, 0);
    check("park_press", {4'b1000, HOME, 1'b1, 1'b0, 1'b0});
    step(0, 4'b0, 4'b0, 2, 0, 1, 0);
    check("park_abort", {4'b1000, HOME, 1'b0, 1'b0, 1'b0});
    step(0, 4'b0, 4'b0, 2, 0, 1, 0);
    check("park_dispatch", {4'b1000, 2'd3, 1'b1, 1'b1, 1'b0});

    // Overload: UP toward 3, floor_btn 0010 under a 5-cycle freeze.
    step(1, 4'b0, 4'b0, 0, 0, 0, 0);
    step(0, 4'b0, 4'b1000, 0, 0, 0, 0);
    step(0, 4'b0, 4'b0, 0, 0, 0, 0);
    check("ovl_setup", {4'b1000, 2'd3, 1'b1, 1'b1, 1'b0});
    step(0, 4'b0010, 4'b0, 0, 0, 1, 1);
    check("ovl_press", {4'b1010, 2'd3, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0, 4'b0, 0, 0, 1, 1);
      check($sformatf("ovl_hold%0d", k), {4'b1010, 2'd3, 1'b1, 1'b1, 1'b0});
    end
    step(0, 4'b0, 4'b0, 0, 0, 1, 0);
    check("ovl_release", {4'b1010, 2'd1, 1'b1, 1'b1, 1'b0});

    // Randomised run against the reference model.
    step(1, 4'b0, 4'b0, 0, 0, 0, 0);
    cf = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      j = i % 400;
      rst = 1'b0; fb = 4'b0; cb = 4'b0; od = 1'b0; busy = 1'b0; ovl = 1'b0;
      if (j < 8) begin
        // Sweep all floors with doors open to drain requests.
        cf = 2'(j % 4);
        od = 1'b1;
      end else if (j < 40) begin
        cf = 2'(1 + (i / 400) % 3);
      end else begin
        if ($urandom % 8 == 0) fb = 4'(1 << ($urandom % 4));
        if ($urandom % 8 == 0) cb = 4'(1 << ($urandom % 4));
        if ($urandom % 4 == 0) begin
          if ($urandom % 2 == 0) cf = (cf == 2'd3) ? cf : cf + 2'd1;
          else                   cf = (cf == 2'd0) ? cf : cf - 2'd1;
        end
        od   = ($urandom % 3 == 0);
        busy = ($urandom % 2 == 0);
        ovl  = ($urandom % 12 == 0);
        rst  = ($urandom % 500 == 0);
      end
      step(rst, fb, cb, cf, od, busy, ovl);
      check($sformatf("rand%0d", i), model_obs());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
